// File: rtl/fht_pkg.sv
// Shared types, defaults and helpers for the FHT sample loader.
package fht_pkg;

    localparam int N_DEFAULT     = 1024;
    localparam int A_BIT_DEFAULT = 8;
    localparam int ADC_W_DEFAULT = 15;
    localparam int N_BANKS       = 4;
    localparam int GAP_CYCLES    = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GAP,
        ST_START,
        ST_WAIT_FHT
    } state_t;

    // Quarter index to bank index: quarters 0,1,2,3 land in banks 0,2,1,3.
    function automatic logic [1:0] bitrev2(input logic [1:0] q);
        return {q[0], q[1]};
    endfunction

    function automatic logic [N_BANKS-1:0] bank_we(input logic [1:0] bank);
        return N_BANKS'(1) << bank;
    endfunction

endpackage

// File: rtl/fht_loader.sv
// Captures one N-point frame of ADC samples into the four FHT banks and starts the transform.
// Optional overflow counter output oOVF_CNT is built when FHT_LOADER_OVF_CNT_EN is defined.
module fht_loader
    import fht_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int A_BIT = A_BIT_DEFAULT,
    parameter int ADC_W = ADC_W_DEFAULT
) (
    input  logic                    iCLK,
    input  logic                    iRESET,
    input  logic signed [ADC_W-1:0] iADC_DATA,
    input  logic                    iADC_VALID,
    input  logic                    iEN,
    input  logic                    iFHT_RDY,
    output logic signed [ADC_W-1:0] oDATA,
    output logic [A_BIT-1:0]        oADDR_WR,
    output logic [N_BANKS-1:0]      oWE,
    output logic                    oSTART,
    output logic                    oBUSY,
    output logic                    oFRAME_DONE
`ifdef FHT_LOADER_OVF_CNT_EN
    ,
    output logic [15:0]             oOVF_CNT
`endif
);

    localparam int K_W = A_BIT + 2;
    localparam logic [K_W-1:0] K_LAST = K_W'(N - 1);

    state_t               state;
    state_t               state_nxt;
    logic [K_W-1:0]       k;
    logic [1:0]           cnt;
    logic                 accept;
    logic                 load_entry;
    logic [N_BANKS-1:0]   we_d;
    logic                 start_d;
    logic                 done_d;

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (iEN && iFHT_RDY) state_nxt = ST_LOAD;
            ST_LOAD:     if (iADC_VALID && k == K_LAST) state_nxt = ST_GAP;
            ST_GAP:      if (cnt == 2'(GAP_CYCLES - 1)) state_nxt = ST_START;
            ST_START:    state_nxt = ST_WAIT_FHT;
            // cnt==0 is the first WAIT_FHT cycle, where fht_top may still show the old RDY
            ST_WAIT_FHT: if (cnt != 2'd0 && iFHT_RDY) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        accept     = (state == ST_LOAD) && iADC_VALID;
        load_entry = (state == ST_IDLE) && (state_nxt == ST_LOAD);
        we_d       = accept ? bank_we(bitrev2(k[A_BIT+1:A_BIT])) : '0;
        start_d    = (state == ST_START);
        done_d     = (state == ST_WAIT_FHT) && (cnt != 2'd0) && iFHT_RDY;
        oBUSY      = (state != ST_IDLE);
    end

    // k wraps naturally from N-1 to 0 because N == 2**K_W
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            k   <= '0;
            cnt <= '0;
        end else begin
            if (load_entry)  k <= '0;
            else if (accept) k <= k + K_W'(1);
            if (state_nxt != state) cnt <= '0;
            else if (cnt != 2'd3)   cnt <= cnt + 2'd1;
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            oWE         <= '0;
            oSTART      <= 1'b0;
            oFRAME_DONE <= 1'b0;
            oDATA       <= '0;
            oADDR_WR    <= '0;
        end else begin
            oWE         <= we_d;
            oSTART      <= start_d;
            oFRAME_DONE <= done_d;
            if (accept) begin
                oDATA    <= iADC_DATA;
                oADDR_WR <= k[A_BIT-1:0];
            end
        end
    end

`ifdef FHT_LOADER_OVF_CNT_EN
    // Samples offered while armed but not loading are lost; count them, saturating.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET)
            oOVF_CNT <= '0;
        else if (load_entry)
            oOVF_CNT <= '0;
        else if (iADC_VALID && iEN && state != ST_LOAD && oOVF_CNT != 16'hFFFF)
            oOVF_CNT <= oOVF_CNT + 16'd1;
    end
`endif

endmodule
